// File: rtl/start_screen_sequencer_if.sv
// start_screen_sequencer_if: frame/key/game-core inputs and layer-enable outputs of the start screen
interface start_screen_sequencer_if;
    logic startOfFrame;
    logic keyStart;
    logic gameOver;
    logic spaceEn;
    logic startEn;
    logic creditEn;
    logic namesEn;
    logic screenActive;
    logic gameStart;
    modport master (
        output startOfFrame, keyStart, gameOver,
        input  spaceEn, startEn, creditEn, namesEn, screenActive, gameStart
    );
    modport slave (
        input  startOfFrame, keyStart, gameOver,
        output spaceEn, startEn, creditEn, namesEn, screenActive, gameStart
    );
endinterface

// File: rtl/start_screen_sequencer.sv
// start_screen_sequencer: title reveal, blinking attract screen, exit flash and hand-over to the game
module start_screen_sequencer #(
    parameter int REVEAL_FRAMES = 30,
    parameter int BLINK_FRAMES  = 16,
    parameter int EXIT_FRAMES   = 8
) (
    input logic clk,
    input logic reset,
    start_screen_sequencer_if.slave bus
);
    localparam int RF = REVEAL_FRAMES < 1 ? 1 : REVEAL_FRAMES;
    localparam int BF = BLINK_FRAMES < 1 ? 1 : BLINK_FRAMES;
    localparam int EF = EXIT_FRAMES < 1 ? 1 : EXIT_FRAMES;
    localparam logic [7:0] RF_LAST = 8'(RF - 1);
    localparam logic [7:0] BF_LAST = 8'(BF - 1);
    localparam logic [7:0] EF_LAST = 8'(EF - 1);
    typedef enum logic [1:0] {REVEAL, ATTRACT, EXIT, DONE} state_t;
    state_t state_q, state_d;
    logic [7:0] frame_cnt_q, frame_cnt_d;
    logic key_q, key_d;
    logic space_q, space_d;
    logic start_q, start_d;
    logic credit_q, credit_d;
    logic names_q, names_d;
    logic active_q, active_d;
    logic game_start_q, game_start_d;
    logic sof, press, entering, blink_wrap;
    always_comb begin
        sof        = bus.startOfFrame;
        key_d      = bus.keyStart;
        press      = bus.keyStart & ~key_q;
        state_d    = state_q == REVEAL  && sof && frame_cnt_q == RF_LAST ? ATTRACT :
                     state_q == ATTRACT && press                        ? EXIT    :
                     state_q == EXIT    && sof && frame_cnt_q == EF_LAST ? DONE    :
                     state_q == DONE    && bus.gameOver                 ? REVEAL  : state_q;
        entering   = state_d != state_q;
        blink_wrap = state_q == ATTRACT && sof && frame_cnt_q == BF_LAST;
        frame_cnt_d = entering || blink_wrap ? 8'd0 :
                      sof ? (frame_cnt_q == 8'hff ? 8'hff : frame_cnt_q + 8'd1) : frame_cnt_q;
        space_d    = state_d == REVEAL || state_d == ATTRACT ||
                     (state_d == EXIT && !entering && (sof ? ~space_q : space_q));
        start_d    = state_d == ATTRACT || (state_d == EXIT && space_d);
        credit_d   = state_d == ATTRACT && (entering || (blink_wrap ? ~credit_q : credit_q));
        names_d    = state_d == ATTRACT;
        active_d   = state_d != DONE;
        game_start_d = state_q == EXIT && state_d == DONE;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= REVEAL;
            frame_cnt_q  <= 8'd0;
            key_q        <= 1'b0;
            space_q      <= 1'b1;
            start_q      <= 1'b0;
            credit_q     <= 1'b0;
            names_q      <= 1'b0;
            active_q     <= 1'b1;
            game_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            key_q        <= key_d;
            space_q      <= space_d;
            start_q      <= start_d;
            credit_q     <= credit_d;
            names_q      <= names_d;
            active_q     <= active_d;
            game_start_q <= game_start_d;
        end
    end
    assign bus.spaceEn      = space_q;
    assign bus.startEn      = start_q;
    assign bus.creditEn     = credit_q;
    assign bus.namesEn      = names_q;
    assign bus.screenActive = active_q;
    assign bus.gameStart    = game_start_q;
endmodule

// File: tb/tb_start_screen_sequencer.sv
// tb_start_screen_sequencer: directed scoreboard bench for the start screen sequencer
module tb_start_screen_sequencer;
    logic clk = 1'b0;
    logic reset;
    start_screen_sequencer_if bus();
    start_screen_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;
    // outputs packed as {spaceEn, startEn, creditEn, namesEn, screenActive, gameStart}
    localparam logic [5:0] O_REVEAL   = 6'b100010;
    localparam logic [5:0] O_ATTR_C1  = 6'b111110;
    localparam logic [5:0] O_ATTR_C0  = 6'b110110;
    localparam logic [5:0] O_EXIT_ON  = 6'b110010;
    localparam logic [5:0] O_EXIT_OFF = 6'b000010;
    localparam logic [5:0] O_DONE     = 6'b000000;
    localparam logic [5:0] O_DONE_GS  = 6'b000001;
    typedef struct {
        string      tag;
        logic [5:0] exp;
    } exp_t;
    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;
    task automatic step(input logic sof, input logic go, input string tag, input logic [5:0] exp);
        exp_t e;
        logic [5:0] obs;
        bus.startOfFrame = sof;
        bus.gameOver     = go;
        e.tag = tag;
        e.exp = exp;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.startOfFrame = 1'b0;
        bus.gameOver     = 1'b0;
        e   = sb.pop_front();
        obs = {bus.spaceEn, bus.startEn, bus.creditEn, bus.namesEn, bus.screenActive, bus.gameStart};
        vectors++;
        assert (obs === e.exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
        end
    endtask
    initial begin
        bus.startOfFrame = 1'b0;
        bus.keyStart     = 1'b0;
        bus.gameOver     = 1'b0;
        reset = 1'b1;
        step(0, 0, "reset", O_REVEAL);
        step(1, 0, "reset_sof", O_REVEAL);
        reset = 1'b0;
        for (int i = 1; i <= 30; i++) step(1, 0, "reveal", i == 30 ? O_ATTR_C1 : O_REVEAL);
        step(0, 0, "attract_idle", O_ATTR_C1);
        for (int i = 1; i <= 64; i++) step(1, 0, "blink", ((i / 16) % 2) != 0 ? O_ATTR_C0 : O_ATTR_C1);
        step(0, 1, "gameover_in_attract", O_ATTR_C1);
        for (int i = 1; i <= 15; i++) step(1, 0, "pre_boundary", O_ATTR_C1);
        bus.keyStart = 1'b1;
        step(1, 0, "press_on_boundary", O_EXIT_OFF);
        for (int i = 1; i <= 7; i++) begin
            if (i == 3) bus.keyStart = 1'b0;
            if (i == 5) bus.keyStart = 1'b1;
            step(1, 0, "exit_flash", (i % 2) != 0 ? O_EXIT_ON : O_EXIT_OFF);
            step(0, 0, "exit_hold", (i % 2) != 0 ? O_EXIT_ON : O_EXIT_OFF);
        end
        step(1, 0, "exit_gamestart", O_DONE_GS);
        step(0, 0, "done", O_DONE);
        bus.keyStart = 1'b0;
        step(0, 0, "done_release", O_DONE);
        bus.keyStart = 1'b1;
        step(0, 0, "done_press", O_DONE);
        step(0, 1, "gameover_in_done", O_REVEAL);
        for (int i = 1; i <= 30; i++) begin
            if (i == 10) bus.keyStart = 1'b0;
            if (i == 11) bus.keyStart = 1'b1;
            step(1, 0, "reveal_again", i == 30 ? O_ATTR_C1 : O_REVEAL);
        end
        for (int i = 0; i < 5; i++) step(0, 0, "held_through_reveal", O_ATTR_C1);
        bus.keyStart = 1'b0;
        step(0, 0, "release", O_ATTR_C1);
        bus.keyStart = 1'b1;
        step(0, 0, "repress", O_EXIT_OFF);
        for (int i = 1; i <= 3; i++) step(1, 0, "exit_before_reset", (i % 2) != 0 ? O_EXIT_ON : O_EXIT_OFF);
        reset = 1'b1;
        step(0, 0, "reset_mid_exit", O_REVEAL);
        step(1, 0, "reset_mid_exit_sof", O_REVEAL);
        reset = 1'b0;
        for (int i = 1; i <= 30; i++) step(1, 0, "reveal_key_held", i == 30 ? O_ATTR_C1 : O_REVEAL);
        for (int i = 0; i < 8; i++) step(0, 0, "held_from_reset", O_ATTR_C1);
        bus.keyStart = 1'b0;
        step(0, 0, "release2", O_ATTR_C1);
        bus.keyStart = 1'b1;
        step(0, 0, "press2", O_EXIT_OFF);
        for (int i = 1; i <= 8; i++)
            step(1, 0, "exit_final", i == 8 ? O_DONE_GS : ((i % 2) != 0 ? O_EXIT_ON : O_EXIT_OFF));
        step(0, 0, "done_final", O_DONE);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/start_screen_sequencer.md
START_SCREEN_SEQUENCER -- requirements
Module: start_screen_sequencer

Interface
REQ-001 Parameter REVEAL_FRAMES, default 30, frames the title layer shows alone before the start layer is enabled.
REQ-002 Parameter BLINK_FRAMES, default 16, half-period in frames of the credit-layer blink.
REQ-003 Parameter EXIT_FRAMES, default 8, frames of the exit flash after the start key is accepted.
REQ-004 clk  input  1  system clock; single clock domain.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-006 startOfFrame  input  1  one-clk pulse at the start of each video frame; the frame tick.
REQ-007 keyStart  input  1  start-key level, already debounced and synchronous to clk.
REQ-008 gameOver  input  1  one-clk pulse from the game core that requests a return to the start screen.
REQ-009 spaceEn  output  1  enables the title ("space invaders") layer drawing request.
REQ-010 startEn  output  1  enables the "press start" layer drawing request.
REQ-011 creditEn  output  1  enables the credit layer drawing request; blinks.
REQ-012 namesEn  output  1  enables the names layer drawing request.
REQ-013 screenActive  output  1  high while the start screen owns the display.
REQ-014 gameStart  output  1  one-clk pulse when the start screen hands over to the game.

Function
REQ-015 States: REVEAL, ATTRACT, EXIT, DONE; all outputs SHALL be registered.
REQ-016 frameCnt (8-bit) SHALL increment on each startOfFrame, saturate at 255, and clear to 0 on every state transition.
REQ-017 REVEAL: spaceEn=1, all other enables 0, screenActive=1; SHALL go to ATTRACT on the startOfFrame on which frameCnt==REVEAL_FRAMES-1.
REQ-018 ATTRACT: spaceEn=1, startEn=1, namesEn=1, screenActive=1.
REQ-019 ATTRACT: creditEn SHALL toggle on each startOfFrame on which frameCnt reaches BLINK_FRAMES-1; the blink counter SHALL wrap to 0 at that point; creditEn SHALL be 1 on entry to ATTRACT.
REQ-020 keyStart SHALL be edge-detected with one register; a press is a 0->1 transition.
REQ-021 A press in ATTRACT SHALL move the FSM to EXIT on the next clk, independent of startOfFrame.
REQ-022 Presses in REVEAL, EXIT and DONE SHALL be ignored; a key held through REVEAL SHALL NOT count as a press on entry to ATTRACT.
REQ-023 EXIT: screenActive=1, namesEn=0, creditEn=0; spaceEn and startEn SHALL be equal and SHALL toggle on every startOfFrame; both are 0 on entry.
REQ-024 EXIT: after EXIT_FRAMES startOfFrame pulses, the FSM SHALL go to DONE and assert gameStart for exactly that one transition clk.
REQ-025 DONE: all enables 0, screenActive=0, gameStart=0 except on entry.
REQ-026 A gameOver pulse in DONE SHALL move the FSM to REVEAL on the next clk, with frameCnt=0. gameOver SHALL be ignored in all other states.
REQ-027 If startOfFrame and a key press occur in the same clk in ATTRACT, the press SHALL win and the blink toggle SHALL be discarded.
REQ-028 Parameters of 0 SHALL be treated as 1.

Reset
REQ-029 While reset=1: state=REVEAL, frameCnt=0, spaceEn=1, startEn=0, creditEn=0, namesEn=0, screenActive=1, gameStart=0, key edge register=0.
REQ-030 Reset SHALL take precedence over every other input; reset asserted mid-EXIT SHALL abort the exit with no gameStart pulse.

Verification
REQ-031 Reset, then 30 startOfFrame pulses with keyStart=0 -> spaceEn=1 throughout; startEn, namesEn and creditEn rise after the 30th pulse.
REQ-032 In ATTRACT, 64 frames with no key -> creditEn toggles every 16 frames: 1,0,1,0 over four half-periods.
REQ-033 keyStart held high from reset into ATTRACT -> no EXIT; release the key and press it again -> EXIT on the next clk.
REQ-034 Press in ATTRACT, then 8 frames -> spaceEn and startEn alternate 0,1,0,1,...; on the 8th frame gameStart=1 for one clk, then screenActive=0.
REQ-035 Press coincident with startOfFrame at a blink boundary -> EXIT entered and creditEn=0.
REQ-036 gameOver in ATTRACT -> ignored; gameOver in DONE -> REVEAL with spaceEn=1 and screenActive=1 on the next clk; reset pulse mid-EXIT -> REVEAL and no gameStart.
